wave_voice_bank: RTL

- Parametrised multi-voice waveform generator.
- Each of NUM_VOICES voices owns a period divider and a phase counter, and produces square, sawtooth, triangle or sine samples from a shared phase-to-amplitude mapping.
- Enabled voices are summed into one registered mix that feeds the output DAC path.
- Voices are reconfigured through a valid/ready port; changes take effect only at a period boundary, so there are no mid-cycle glitches.

---
 rtl/wave_voice_bank.sv | 131 +++++++++++++
 1 files changed

// File: rtl/wave_voice_bank.sv
// wave_voice_bank: multi-voice square/saw/triangle/sine generator with a registered mix
// and a single-slot config port whose updates land only on waveform period boundaries.
module wave_voice_bank #(
    parameter int NUM_VOICES = 3,
    parameter int PRD_W      = 32,
    parameter int STEP_BITS  = 5,
    parameter int SAMPLE_W   = 4,
    parameter int OUT_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_voice,
    input  logic [PRD_W-1:0] cfg_period,
    input  logic [1:0]       cfg_wave,
    input  logic             cfg_en,
    output logic [OUT_W-1:0] mix,
    output logic [3:0]       active_cnt
);
    localparam int STEPS = 1 << STEP_BITS;
    localparam int MAX   = (1 << SAMPLE_W) - 1;

    // Q28 Taylor series on a first-quadrant angle keeps the zero crossings and peaks exact.
    function automatic logic [STEPS*SAMPLE_W-1:0] sine_tab();
        logic [STEPS*SAMPLE_W-1:0] tab;
        longint a, s, term, v;
        int q;
        tab = '0;
        for (int p = 0; p < STEPS; p++) begin
            q = p % (STEPS / 4);
            if ((p / (STEPS / 4)) % 2 == 1) q = STEPS / 4 - q;
            a = 64'sd1686629713 * longint'(q) / longint'(STEPS);
            s = a;
            term = a;
            for (int k = 1; k < 7; k++) begin
                term = -((((term * a) >>> 28) * a) >>> 28) / longint'(2 * k * (2 * k + 1));
                s = s + term;
            end
            if (p >= STEPS / 2) s = -s;
            v = (longint'(MAX) * ((64'sd1 <<< 28) + s) + (64'sd1 <<< 28)) >>> 29;
            tab[p*SAMPLE_W +: SAMPLE_W] = v[SAMPLE_W-1:0];
        end
        return tab;
    endfunction

    localparam logic [STEPS*SAMPLE_W-1:0] SINE = sine_tab();

    logic                  pend, pend_en;
    logic [2:0]            pend_voice;
    logic [PRD_W-1:0]      pend_period;
    logic [1:0]            pend_wave;
    logic [NUM_VOICES-1:0] en, apply;
    logic [SAMPLE_W-1:0]   samp [NUM_VOICES];
    logic [OUT_W-1:0]      sum;
    logic [3:0]            cnt;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        logic                 on, tick;
        logic [PRD_W-1:0]     per, dv, shr, step_len;
        logic [1:0]           wv;
        logic [STEP_BITS-1:0] ph;
        logic [SAMPLE_W-1:0]  tri_v;
        assign shr      = per >> STEP_BITS;
        assign step_len = shr == '0 ? PRD_W'(1) : shr;
        assign tick     = on && dv == step_len - PRD_W'(1);
        assign apply[g] = pend && pend_voice == 3'(g) && (!on || (tick && &ph));
        assign tri_v    = ph[STEP_BITS-2 -: SAMPLE_W];
        assign en[g]    = on;
        assign samp[g]  = !on ? '0 :
                          wv == 2'd0 ? {SAMPLE_W{ph[STEP_BITS-1]}} :
                          wv == 2'd1 ? ph[STEP_BITS-1 -: SAMPLE_W] :
                          wv == 2'd2 ? (ph[STEP_BITS-1] ? ~tri_v : tri_v) :
                          SINE[int'(ph)*SAMPLE_W +: SAMPLE_W];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                on  <= 1'b0;
                per <= '0;
                wv  <= '0;
                ph  <= '0;
                dv  <= '0;
            end else if (apply[g]) begin
                on  <= pend_en;
                per <= pend_period;
                wv  <= pend_wave;
                ph  <= '0;
                dv  <= '0;
            end else if (tick) begin
                ph  <= ph + STEP_BITS'(1);
                dv  <= '0;
            end else if (on) begin
                dv  <= dv + PRD_W'(1);
            end
        end
    end

    always_comb begin
        sum = '0;
        cnt = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            sum = sum + OUT_W'(samp[k]);
            cnt = cnt + 4'(en[k]);
        end
    end

    assign cfg_ready = !pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend        <= 1'b0;
            pend_en     <= 1'b0;
            pend_voice  <= '0;
            pend_period <= '0;
            pend_wave   <= '0;
            mix         <= '0;
            active_cnt  <= '0;
        end else begin
            mix        <= sum;
            active_cnt <= cnt;
            if (cfg_valid && cfg_ready) begin
                pend        <= {1'b0, cfg_voice} < 4'(NUM_VOICES);
                pend_en     <= cfg_en;
                pend_voice  <= cfg_voice;
                pend_period <= cfg_period;
                pend_wave   <= cfg_wave;
            end else if (|apply) begin
                pend <= 1'b0;
            end
        end
    end
endmodule
